// File: rtl/cnn_para_pkg.sv
// Shared types and width helpers for the conv-layer parameter sequencer.
package cnn_para_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int w_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int aw_w(input int nf, input int nch, input int k);
    return w_min1(nf * nch * k);
  endfunction

  function automatic int fw_w(input int nf);
    return w_min1(nf);
  endfunction

  function automatic int cw_w(input int nch);
    return w_min1(nch);
  endfunction

  function automatic int rw_w(input int k);
    return w_min1(k);
  endfunction

endpackage

// File: rtl/para_store.sv
// Kernel-row and bias register files with one write port each and a registered read.
module para_store import cnn_para_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int K      = 3,
  parameter int N_FILT = 4,
  parameter int N_CH   = 2,
  localparam int DEPTH = N_FILT * N_CH * K,
  localparam int AW    = aw_w(N_FILT, N_CH, K),
  localparam int FW    = fw_w(N_FILT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [K*DW-1:0] wr_data,
  input  logic            bwr_en,
  input  logic [FW-1:0]   bwr_addr,
  input  logic [DW-1:0]   bwr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [FW-1:0]   rd_f,
  output logic [K*DW-1:0] rd_row,
  output logic [DW-1:0]   rd_bias
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [FW:0] NF_L    = (FW+1)'(N_FILT);

  logic [K*DW-1:0] rows   [DEPTH];
  logic [DW-1:0]   biases [N_FILT];

  // Storage itself is never reset so coefficients survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L))
      rows[wr_addr] <= wr_data;
    if (bwr_en && ({1'b0, bwr_addr} < NF_L))
      biases[bwr_addr] <= bwr_data;
  end

  // The read registers double as the beat output registers: a write landing
  // on the held row cannot disturb it, and same-cycle write/read sees old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_row  <= '0;
      rd_bias <= '0;
    end else if (rd_en) begin
      rd_row  <= rows[rd_addr];
      rd_bias <= biases[rd_f];
    end
  end

endmodule

// File: rtl/para_seq_gen.sv
// Filter/bias sequencer: streams kernel rows (r fastest, then filter, then channel)
// with the matching bias under valid/ready, optionally looping with no idle gap.
module para_seq_gen import cnn_para_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int K      = 3,
  parameter int N_FILT = 4,
  parameter int N_CH   = 2,
  localparam int AW    = aw_w(N_FILT, N_CH, K),
  localparam int FW    = fw_w(N_FILT),
  localparam int CW    = cw_w(N_CH),
  localparam int RW    = rw_w(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            loop_en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [K*DW-1:0] wr_data,
  input  logic            bwr_en,
  input  logic [FW-1:0]   bwr_addr,
  input  logic [DW-1:0]   bwr_data,
  output logic [K*DW-1:0] filt,
  output logic [DW-1:0]   bias,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ch,
  output logic [FW-1:0]   out_f,
  output logic [RW-1:0]   out_row,
  output logic            out_last,
  output logic            done,
  output logic            busy
);

  state_t          state_q, state_d;
  logic            acc, ld, first, drop_valid, done_d;
  logic            r_wrap, f_wrap;
  logic [RW-1:0]   nxt_r;
  logic [FW-1:0]   nxt_f;
  logic [CW-1:0]   nxt_ch;
  logic [AW-1:0]   nxt_addr;
  logic            nxt_last;

  assign acc  = out_valid & out_ready;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    first      = 1'b0;
    drop_valid = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        ld      = 1'b1;
        first   = 1'b1;
        state_d = RUN;
      end
      RUN: if (acc) begin
        if (out_last) begin
          done_d = 1'b1;
          // Counters wrap to (0,0,0) after the last beat, so looping is just another load.
          if (loop_en) ld = 1'b1;
          else begin
            drop_valid = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          ld = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_wrap = (out_row == RW'(K - 1));
    f_wrap = (out_f == FW'(N_FILT - 1));
    nxt_r  = r_wrap ? '0 : out_row + 1'b1;
    nxt_f  = out_f;
    nxt_ch = out_ch;
    if (r_wrap) begin
      nxt_f = f_wrap ? '0 : out_f + 1'b1;
      if (f_wrap)
        nxt_ch = (out_ch == CW'(N_CH - 1)) ? '0 : out_ch + 1'b1;
    end
    if (first) begin
      nxt_r  = '0;
      nxt_f  = '0;
      nxt_ch = '0;
    end
    nxt_last = (nxt_ch == CW'(N_CH - 1)) && (nxt_f == FW'(N_FILT - 1)) &&
               (nxt_r == RW'(K - 1));
    nxt_addr = AW'((int'(nxt_f) * N_CH + int'(nxt_ch)) * K + int'(nxt_r));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_f     <= '0;
      out_ch    <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_d;
      if (ld) begin
        out_valid <= 1'b1;
        out_last  <= nxt_last;
        out_row   <= nxt_r;
        out_f     <= nxt_f;
        out_ch    <= nxt_ch;
      end else if (drop_valid) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  para_store #(
    .DW(DW), .K(K), .N_FILT(N_FILT), .N_CH(N_CH)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .bwr_en   (bwr_en),
    .bwr_addr (bwr_addr),
    .bwr_data (bwr_data),
    .rd_en    (ld),
    .rd_addr  (nxt_addr),
    .rd_f     (nxt_f),
    .rd_row   (filt),
    .rd_bias  (bias)
  );

endmodule

// File: tb/tb_para_seq_gen.sv
// Directed bench: default layer (16b, K=3, 4 filters, 2 ch) plus a 8b K=5 3-filter 1-ch layer.
module tb_para_seq_gen;

  logic clk, rst;
  int checks, errors;

  logic        start, loop_en, wr_en, bwr_en, out_ready;
  logic [4:0]  wr_addr;
  logic [47:0] wr_data;
  logic [1:0]  bwr_addr;
  logic [15:0] bwr_data;
  logic [47:0] filt;
  logic [15:0] bias;
  logic        out_valid, out_last, done, busy;
  logic [0:0]  out_ch;
  logic [1:0]  out_f, out_row;

  logic        b_start, b_loop_en, b_wr_en, b_bwr_en, b_out_ready;
  logic [3:0]  b_wr_addr;
  logic [39:0] b_wr_data;
  logic [1:0]  b_bwr_addr;
  logic [7:0]  b_bwr_data;
  logic [39:0] b_filt;
  logic [7:0]  b_bias;
  logic        b_out_valid, b_out_last, b_done, b_busy;
  logic [0:0]  b_out_ch;
  logic [1:0]  b_out_f;
  logic [2:0]  b_out_row;

  logic [15:0] mem_m [24];

  para_seq_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bwr_en(bwr_en), .bwr_addr(bwr_addr), .bwr_data(bwr_data),
    .filt(filt), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_f(out_f), .out_row(out_row), .out_last(out_last),
    .done(done), .busy(busy)
  );

  para_seq_gen #(.DW(8), .K(5), .N_FILT(3), .N_CH(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .loop_en(b_loop_en),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .bwr_en(b_bwr_en), .bwr_addr(b_bwr_addr), .bwr_data(b_bwr_data),
    .filt(b_filt), .bias(b_bias), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ch(b_out_ch), .out_f(b_out_f), .out_row(b_out_row), .out_last(b_out_last),
    .done(b_done), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Beat n of the default layer: r fastest, then filter, then channel.
  task automatic beat_a(input int n, input string t);
    int r, f, ch, a;
    string s;
    r = n % 3; f = (n / 3) % 4; ch = n / 12; a = (f * 2 + ch) * 3 + r;
    s = $sformatf("%s%0d", t, n);
    chk({s, "_valid"}, 64'(out_valid), 64'(1));
    chk({s, "_filt"},  64'(filt), 64'({3{mem_m[a]}}));
    chk({s, "_bias"},  64'(bias), 64'(16'h0036 + f));
    chk({s, "_row"},   64'(out_row), 64'(r));
    chk({s, "_f"},     64'(out_f), 64'(f));
    chk({s, "_ch"},    64'(out_ch), 64'(ch));
    chk({s, "_last"},  64'(out_last), 64'(n == 23));
  endtask

  task automatic beat_b(input int n);
    string s;
    s = $sformatf("b%0d", n);
    chk({s, "_valid"}, 64'(b_out_valid), 64'(1));
    chk({s, "_filt"},  64'(b_filt), 64'({5{8'(8'h40 + n)}}));
    chk({s, "_bias"},  64'(b_bias), 64'(8'h20 + n / 5));
    chk({s, "_row"},   64'(b_out_row), 64'(n % 5));
    chk({s, "_f"},     64'(b_out_f), 64'(n / 5));
    chk({s, "_ch"},    64'(b_out_ch), 64'(0));
    chk({s, "_last"},  64'(b_out_last), 64'(n == 14));
  endtask

  task automatic start_a();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    start = 0; loop_en = 0; wr_en = 0; bwr_en = 0; out_ready = 1;
    wr_addr = '0; wr_data = '0; bwr_addr = '0; bwr_data = '0;
    b_start = 0; b_loop_en = 0; b_wr_en = 0; b_bwr_en = 0; b_out_ready = 1;
    b_wr_addr = '0; b_wr_data = '0; b_bwr_addr = '0; b_bwr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_filt",  64'(filt), 64'(0));
    chk("rst_bias",  64'(bias), 64'(0));
    chk("rst_idx",   64'({out_ch, out_f, out_row, out_last}), 64'(0));
    chk("rst_b_valid", 64'(b_out_valid), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Load both coefficient sets.
    for (int i = 0; i < 24; i++) begin
      mem_m[i] = 16'(16'h0100 + i);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = {3{16'(16'h0100 + i)}};
      bwr_en = (i < 4); bwr_addr = 2'(i); bwr_data = 16'(16'h0036 + i);
      b_wr_en = (i < 15); b_wr_addr = 4'(i); b_wr_data = {5{8'(8'h40 + i)}};
      b_bwr_en = (i < 3); b_bwr_addr = 2'(i); b_bwr_data = 8'(8'h20 + i);
      @(negedge clk);
    end
    wr_en = 0; bwr_en = 0; b_wr_en = 0; b_bwr_en = 0;

    // Full sequence, start pulsed mid-run must be ignored.
    start_a();
    for (int n = 0; n < 24; n++) begin
      beat_a(n, "seq");
      start = (n == 10);
      @(negedge clk);
    end
    start = 0;
    chk("seq_done", 64'(done), 64'(1));
    chk("seq_end_valid", 64'(out_valid), 64'(0));
    chk("seq_end_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("seq_done_pulse", 64'(done), 64'(0));

    // Backpressure at beat 5.
    start_a();
    for (int n = 0; n < 24; n++) begin
      beat_a(n, "bp");
      if (n == 4) begin
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          beat_a(n, "bp_hold");
          chk("bp_hold_done", 64'(done), 64'(0));
        end
        out_ready = 1;
      end
      @(negedge clk);
    end
    chk("bp_done", 64'(done), 64'(1));
    chk("bp_end_valid", 64'(out_valid), 64'(0));

    // Loop mode with live writes: addr 7 while held, addr 8 in the cycle it is read.
    loop_en = 1;
    start_a();
    for (int n = 0; n < 24; n++) begin
      wr_en = 0;
      beat_a(n, "lp1_");
      if (n == 5) begin
        mem_m[7] = 16'hBEEF;
        mem_m[8] = 16'hCAFE;
      end
      if (n == 4) begin
        out_ready = 0;
        wr_en = 1; wr_addr = 5'd7; wr_data = {3{16'hBEEF}};
        @(negedge clk);
        wr_en = 0;
        beat_a(n, "lp_held");
        out_ready = 1;
        wr_en = 1; wr_addr = 5'd8; wr_data = {3{16'hCAFE}};
      end
      @(negedge clk);
    end
    wr_en = 0;
    chk("lp_done", 64'(done), 64'(1));
    beat_a(0, "lp2_");
    @(negedge clk);
    chk("lp_done_once", 64'(done), 64'(0));
    for (int n = 1; n < 10; n++) begin
      beat_a(n, "lp2_");
      if (n < 9) @(negedge clk);
    end

    // Asynchronous reset mid-run, away from any clock edge.
    #2 rst = 0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy",  64'(busy), 64'(0));
    chk("mrst_done",  64'(done), 64'(0));
    chk("mrst_filt",  64'(filt), 64'(0));
    @(negedge clk);
    rst = 1; loop_en = 0;
    @(negedge clk);
    chk("mrst_idle_busy", 64'(busy), 64'(0));
    start_a();
    for (int n = 0; n < 6; n++) begin
      beat_a(n, "rs");
      @(negedge clk);
    end

    // Alternate geometry: 15 beats, r then f.
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    chk("b_load_valid", 64'(b_out_valid), 64'(0));
    @(negedge clk);
    for (int n = 0; n < 15; n++) begin
      beat_b(n);
      @(negedge clk);
    end
    chk("b_done", 64'(b_done), 64'(1));
    chk("b_end_valid", 64'(b_out_valid), 64'(0));
    @(negedge clk);
    chk("b_done_pulse", 64'(b_done), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
